// File: rtl/cordic_sched_pkg.sv
// Shared definitions for the CORDIC request scheduler: default sizing,
// datapath widths and the controller state encoding.
package cordic_sched_pkg;

  localparam int N_REQ_DEF   = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int DATA_W      = 16;
  localparam int ID_W        = 3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_RESP    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/cordic_sched_rr_arbiter.sv
// Round-robin arbiter: picks the lowest-indexed active request at or above
// ptr, wrapping past the top index back to zero.
module rr_arbiter
  import cordic_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

  int   cand;
  logic found;

  // Walk the requesters in priority order starting at ptr; first hit wins
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr) + i) % N_REQ;
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && cand == k && req[k]) begin
          found     = 1'b1;
          grant[k]  = 1'b1;
          grant_idx = ID_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Shares one CORDIC core between N_REQ requesters. One operation is in
// flight at a time; a watchdog turns a silent core into an error response.
module cordic_sched
  import cordic_sched_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [DATA_W*N_REQ-1:0]  req_angle,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic signed [DATA_W-1:0] resp_cos,
  output logic signed [DATA_W-1:0] resp_sin,
  output logic                     resp_err,
  output logic                     cor_start,
  output logic signed [DATA_W-1:0] cor_angle,
  input  logic signed [DATA_W-1:0] cor_cos,
  input  logic signed [DATA_W-1:0] cor_sin,
  input  logic                     cor_valid,
  output logic                     busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                   state;
  logic [ID_W-1:0]          ptr;
  logic [ID_W-1:0]          ptr_nxt;
  logic [CNT_W-1:0]         cnt;
  logic [N_REQ-1:0]         grant;
  logic [ID_W-1:0]          grant_idx;
  logic signed [DATA_W-1:0] sel_angle;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req      (req_valid),
    .ptr      (ptr),
    .grant    (grant),
    .grant_idx(grant_idx)
  );

  // Priority moves just past the winner so every requester gets its turn
  assign ptr_nxt = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Pick out the winning requester's angle slice
  always_comb begin
    sel_angle = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) sel_angle = req_angle[DATA_W*k +: DATA_W];
    end
  end

  // Controller: grant, drive the core, collect or time out, hand back, drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      req_ready  <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_cos   <= '0;
      resp_sin   <= '0;
      resp_err   <= 1'b0;
      cor_start  <= 1'b0;
      cor_angle  <= '0;
      busy       <= 1'b0;
    end else begin
      req_ready <= '0;
      unique case (state)
        S_IDLE: begin
          if (|req_valid) begin
            req_ready <= grant;
            cor_angle <= sel_angle;
            resp_id   <= grant_idx;
            ptr       <= ptr_nxt;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cor_start <= 1'b1;
          cnt       <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (cor_valid) begin
            resp_cos   <= cor_cos;
            resp_sin   <= cor_sin;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            cor_start  <= 1'b0;
            state      <= S_RESP;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            resp_cos   <= '0;
            resp_sin   <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            cor_start  <= 1'b0;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // A core still showing done must not leak into the next operation
          if (!cor_valid) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          cor_start  <= 1'b0;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: directed table, held-request fairness sequence,
// randomized operations against a scoreboard model, timeout and reset cases.
module tb_cordic_sched;

  localparam int NREQ = 4;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_angle;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [2:0]  resp_id;
  logic [15:0] resp_cos;
  logic [15:0] resp_sin;
  logic        resp_err;
  logic        cor_start;
  logic [15:0] cor_angle;
  logic [15:0] cor_cos;
  logic [15:0] cor_sin;
  logic        cor_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int ptr_m  = 0;

  int stub_lat   = 2;
  int stub_drop  = 1;
  bit stub_never = 1'b0;
  int lat_cnt    = 0;
  int drop_cnt   = 0;

  typedef struct {
    logic [3:0]  rv;
    logic [63:0] ang;
    int          rdy;
    int          id;
    logic [15:0] c;
    logic [15:0] s;
  } vec_t;

  vec_t tbl[4];

  cordic_sched #(.N_REQ(NREQ), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_angle (req_angle),
    .req_ready (req_ready),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_cos  (resp_cos),
    .resp_sin  (resp_sin),
    .resp_err  (resp_err),
    .cor_start (cor_start),
    .cor_angle (cor_angle),
    .cor_cos   (cor_cos),
    .cor_sin   (cor_sin),
    .cor_valid (cor_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Core stand-in: fixed points for 0 and 0x4000, simple mapping elsewhere
  function automatic logic [31:0] stub_fn(input logic [15:0] a);
    if (a == 16'h0000) return {16'h8000, 16'h0000};
    if (a == 16'h4000) return {16'h5A82, 16'h5A82};
    return {a ^ 16'h55AA, a + 16'h0101};
  endfunction

  // Scoreboard model of the arbitration rule
  function automatic int model_grant(input logic [3:0] rv);
    for (int i = 0; i < NREQ; i++) begin
      if (rv[(ptr_m + i) % NREQ]) return (ptr_m + i) % NREQ;
    end
    return 0;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Behavioural core: done after stub_lat cycles of start, lingers stub_drop cycles
  initial begin
    cor_valid = 1'b0;
    cor_cos   = '0;
    cor_sin   = '0;
    forever begin
      @(posedge clk);
      #1;
      if (cor_start) begin
        drop_cnt = stub_drop;
        if (!stub_never && lat_cnt >= stub_lat) begin
          cor_valid = 1'b1;
          {cor_cos, cor_sin} = stub_fn(cor_angle);
        end else begin
          cor_valid = 1'b0;
          lat_cnt++;
        end
      end else begin
        lat_cnt = 0;
        if (cor_valid) begin
          if (drop_cnt == 0) cor_valid = 1'b0;
          else drop_cnt--;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b0;
    #1;
    chk("reset_state", {req_ready, resp_valid, resp_id, resp_cos, resp_sin, resp_err,
                        cor_start, cor_angle, busy}, 64'd0);
    repeat (2) @(negedge clk);
    chk("reset_hold", {busy, cor_start, req_ready, resp_valid}, 64'd0);
    rst   = 1'b1;
    ptr_m = 0;
  endtask

  // One full transaction from request to return-to-idle
  task automatic run_op(input logic [3:0] rv, input logic [63:0] ang, input bit hold,
                        input int rdy, input int exp_id, input logic [15:0] ec,
                        input logic [15:0] es, input bit exp_err);
    int          n;
    int          cs;
    logic [15:0] a;
    logic [3:0]  eg;
    logic        cvp;
    req_valid = rv;
    req_angle = ang;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 20);
    eg = '0;
    eg[exp_id] = 1'b1;
    chk("grant", req_ready, eg);
    if (req_ready == '0) return;
    ptr_m = (exp_id + 1) % NREQ;
    a = ang[16*exp_id +: 16];
    chk("busy_on_grant", busy, 1);
    if (!hold) req_valid = 4'($urandom);
    @(negedge clk);
    chk("cor_start_rise", cor_start, 1);
    chk("cor_angle", cor_angle, a);
    cs = 0;
    n  = 0;
    while (!resp_valid && n < TMO + 16) begin
      chk("inflight", {req_ready, cor_angle}, {4'b0, a});
      cs += int'(cor_start);
      n++;
      @(negedge clk);
    end
    chk("resp_valid", resp_valid, 1);
    chk("wait_cycles", cs, exp_err ? TMO : stub_lat + 1);
    chk("resp_data", {resp_id, resp_cos, resp_sin, resp_err}, {3'(exp_id), ec, es, exp_err});
    chk("resp_cor_start", cor_start, 0);
    for (int i = 0; i < rdy; i++) begin
      @(negedge clk);
      chk("resp_hold", {resp_valid, resp_id, resp_cos, resp_sin, resp_err, cor_start, req_ready, cor_angle},
                       {1'b1, 3'(exp_id), ec, es, exp_err, 1'b0, 4'b0, a});
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    if (!hold) req_valid = '0;
    chk("resp_done", resp_valid, 0);
    n   = 0;
    cvp = cor_valid;
    while (busy && n < 32) begin
      cvp = cor_valid;
      chk("release", {req_ready, resp_valid, cor_start, cor_angle}, {4'b0, 1'b0, 1'b0, a});
      n++;
      @(negedge clk);
    end
    chk("idle", busy, 0);
    chk("release_cv", cvp, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  rv;
    logic [63:0] ang;
    logic [31:0] cso;
    int          id;
    int          n;

    rst        = 1'b0;
    req_valid  = '0;
    req_angle  = '0;
    resp_ready = 1'b0;

    tbl[0] = '{4'b0100, {16'h1111, 16'h4000, 16'h2222, 16'h3333}, 0,  2, 16'h5A82, 16'h5A82};
    tbl[1] = '{4'b0010, {16'h7777, 16'h6666, 16'h0000, 16'h5555}, 0,  1, 16'h8000, 16'h0000};
    tbl[2] = '{4'b1001, {16'h1234, 16'h0000, 16'h0000, 16'h0ABC}, 10, 3, 16'h479E, 16'h1335};
    tbl[3] = '{4'b1001, {16'h0000, 16'h0000, 16'h0000, 16'h8001}, 2,  0, 16'hD5AB, 16'h8102};

    do_reset();

    stub_lat  = 2;
    stub_drop = 3;
    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i].rv, tbl[i].ang, 1'b0, tbl[i].rdy, tbl[i].id, tbl[i].c, tbl[i].s, 1'b0);
    end

    // All four held from a fresh pointer: strict rotation then wrap
    do_reset();
    stub_lat  = 1;
    stub_drop = 2;
    ang = {16'h0C00, 16'h4000, 16'h0000, 16'h2468};
    for (int i = 0; i < 5; i++) begin
      cso = stub_fn(ang[16*(i%4) +: 16]);
      run_op(4'b1111, ang, i < 4, 0, i % 4, cso[31:16], cso[15:0], 1'b0);
    end

    for (int t = 0; t < 30; t++) begin
      rv        = 4'($urandom_range(1, 15));
      ang       = {$urandom, $urandom};
      stub_lat  = int'($urandom_range(0, 4));
      stub_drop = int'($urandom_range(0, 5));
      id        = model_grant(rv);
      cso       = stub_fn(ang[16*id +: 16]);
      run_op(rv, ang, 1'b0, int'($urandom_range(0, 3)), id, cso[31:16], cso[15:0], 1'b0);
    end

    // Silent core
    stub_never = 1'b1;
    ang = {$urandom, $urandom};
    run_op(4'b0001, ang, 1'b0, 1, model_grant(4'b0001), 16'h0, 16'h0, 1'b1);
    stub_never = 1'b0;

    // Reset in the middle of WAIT, then re-arbitration from pointer zero
    do_reset();
    stub_never = 1'b1;
    ang = {16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD};
    req_valid = 4'b0100;
    req_angle = ang;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 20);
    chk("rst_pre_grant", req_ready, 4'b0100);
    req_valid = 4'b1010;
    repeat (4) @(negedge clk);
    chk("rst_pre_wait", {cor_start, busy, resp_valid}, 3'b110);
    #2 rst = 1'b0;
    #1;
    chk("rst_async", {cor_start, busy, resp_valid, req_ready, cor_angle}, 64'd0);
    @(negedge clk);
    chk("rst_held", {cor_start, busy, resp_valid}, 64'd0);
    rst        = 1'b1;
    ptr_m      = 0;
    stub_never = 1'b0;
    stub_lat   = 1;
    stub_drop  = 0;
    cso = stub_fn(16'h0CCC);
    run_op(4'b1010, ang, 1'b0, 0, 1, cso[31:16], cso[15:0], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cordic_sched.md
CORDIC_SCHED -- requirements
Module: cordic_sched

Interface
Parameters:
REQ-001 N_REQ, 4, number of requesters sharing one cordic core (2..8).
REQ-002 TIMEOUT, 64, max cycles from cor_start rise to cor_valid before error.
Ports:
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  N_REQ  per-requester request pending.
REQ-006 req_angle  in  16*N_REQ  signed normalized angle per requester, slice k = bits [16k+15:16k].
REQ-007 req_ready  out  N_REQ  one-hot, one-cycle pulse = request k accepted.
REQ-008 resp_valid  out  1  result available.
REQ-009 resp_ready  in  1  consumer accepts result.
REQ-010 resp_id  out  3  index of requester owning result.
REQ-011 resp_cos, resp_sin  out  16 each  signed result.
REQ-012 resp_err  out  1  result invalid (timeout), cos/sin = 0.
REQ-013 cor_start  out  1  start level to cordic core.
REQ-014 cor_angle  out  16  angle to cordic core.
REQ-015 cor_cos, cor_sin  in  16 each  core outputs.
REQ-016 cor_valid  in  1  core done level.
REQ-017 busy  out  1  high in any state except IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP, RELEASE.
REQ-019 IDLE: if any req_valid, grant round-robin: lowest index >= ptr, wrapping; pulse req_ready[grant], latch angle to cor_angle and grant to resp_id, ptr <= grant+1 mod N_REQ, go ISSUE.
REQ-020 ISSUE: cor_start=1, clear timeout counter, go WAIT next cycle.
REQ-021 WAIT: cor_start held 1; on cor_valid=1 latch cor_cos/cor_sin, resp_err=0, go RESP.
REQ-022 WAIT: counter increments each cycle; at count==TIMEOUT-1 without cor_valid, set resp_cos=resp_sin=0, resp_err=1, go RESP.
REQ-023 RESP: cor_start=0 from entry; resp_valid=1, outputs stable until resp_ready=1; on resp_valid&&resp_ready go RELEASE.
REQ-024 RELEASE: cor_start=0; wait until cor_valid=0, then go IDLE; no new grant while cor_valid=1.
REQ-025 Grant latency: req_valid high in IDLE -> req_ready pulse same cycle registered (visible next edge); cor_start high one cycle after grant.
REQ-026 Requester k's req_valid SHALL be ignored while another grant is in flight; at most one outstanding operation.
REQ-027 req_valid dropping after grant SHALL NOT cancel the operation.
REQ-028 Simultaneous requests: exactly one grant per IDLE visit; every continuously asserted requester served within N_REQ operations.
REQ-029 resp_ready held high in RESP: handshake completes in one cycle; resp_valid low in all other states.
REQ-030 cor_angle SHALL remain constant from ISSUE through RELEASE.

Reset
REQ-031 rst=0 asynchronously forces state=IDLE, ptr=0, counter=0, and all outputs (req_ready, resp_valid, resp_id, resp_cos, resp_sin, resp_err, cor_start, cor_angle, busy) to 0.
REQ-032 Reset mid-operation drops cor_start immediately; no response emitted for the aborted request.

Structure
REQ-033 Shared package/include SHALL hold FSM state encodings (3-bit), N_REQ and TIMEOUT defaults.
REQ-034 Round-robin grant logic SHALL be sub-module rr_arbiter (inputs req, ptr; output one-hot grant, grant index).

Verification
REQ-035 Single request: req_valid[2]=1, angle 16'h4000 -> req_ready[2] pulse, resp_id=2, resp_cos=resp_sin=16'h5A82, resp_err=0.
REQ-036 All four requesting from ptr=0 -> grants in order 0,1,2,3, then 0; resp_id sequence matches.
REQ-037 Core stub never asserts cor_valid, TIMEOUT=64 -> resp_valid after 64 WAIT cycles, resp_err=1, cos=sin=0, cor_start low.
REQ-038 resp_ready held 0 for 10 cycles in RESP -> outputs stable, no new grant, cor_start=0; release then next grant.
REQ-039 rst low during WAIT -> cor_start=0 same cycle, busy=0, no resp_valid; after release, pending request regranted from ptr=0.
REQ-040 Angle 16'h0000 from requester 1 -> resp_cos=16'h8000, resp_sin=0, resp_id=1.
